// File: rtl/pic_inta_sequencer.sv
// 8259-style INTA sequencer: resolves fixed-priority requests against the
// in-service register, drives INT, and runs the two-pulse 8086 acknowledge.
module pic_inta_sequencer #(
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] irr,
    input  logic [7:0] imr,
    input  logic [4:0] icw2_vec,
    input  logic       aeoi,
    input  logic       eoi_ns,
    input  logic       eoi_sp,
    input  logic [2:0] eoi_level,
    input  logic       inta_n,
    output logic       int_out,
    output logic [7:0] irr_clr,
    output logic [7:0] isr,
    output logic [7:0] data_out,
    output logic       data_oe
);

    typedef enum logic [1:0] {IDLE, ACK1, WAIT2, ACK2} state_t;

    state_t                 state_q, state_d;
    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   edge_q, edge_d;
    logic                   int_q, int_d;
    logic [7:0]             irr_clr_q, irr_clr_d;
    logic [7:0]             isr_q, isr_d;
    logic [7:0]             data_q, data_d;
    logic                   oe_q, oe_d;
    logic [2:0]             idx_q, idx_d;
    logic                   spur_q, spur_d;

    logic       inta_fall, inta_rise;
    logic [7:0] pend;
    logic [3:0] win, top_isr;
    logic       valid;
    logic [7:0] isr_set, isr_clr, aeoi_clr;

    // Lowest set index, 8 when the vector is empty (IR0 is highest priority).
    function automatic logic [3:0] lowest(input logic [7:0] v);
        logic [3:0] r;
        r = 4'd8;
        for (int i = 7; i >= 0; i--)
            if (v[i]) r = i[3:0];
        return r;
    endfunction

    function automatic logic [7:0] onehot(input logic [2:0] n);
        return 8'b1 << n;
    endfunction

    assign sync_d    = {sync_q[SYNC_STAGES-2:0], inta_n};
    assign edge_d    = sync_q[SYNC_STAGES-1];
    assign inta_fall = edge_q & ~sync_q[SYNC_STAGES-1];
    assign inta_rise = ~edge_q & sync_q[SYNC_STAGES-1];

    assign pend    = irr & ~imr;
    assign win     = lowest(pend);
    assign top_isr = lowest(isr_q);
    assign valid   = (pend != 8'd0) && (win < top_isr);

    always_comb begin
        state_d   = state_q;
        int_d     = int_q;
        irr_clr_d = 8'd0;
        data_d    = data_q;
        oe_d      = oe_q;
        idx_d     = idx_q;
        spur_d    = spur_q;
        isr_set   = 8'd0;
        aeoi_clr  = 8'd0;
        case (state_q)
            IDLE: begin
                int_d = valid;
                if (inta_fall) begin
                    state_d = ACK1;
                    int_d   = 1'b0;
                    if (valid) begin
                        idx_d     = win[2:0];
                        isr_set   = onehot(win[2:0]);
                        irr_clr_d = onehot(win[2:0]);
                        spur_d    = 1'b0;
                    end else begin
                        idx_d  = 3'd7;
                        spur_d = 1'b1;
                    end
                end
            end
            ACK1: begin
                int_d = 1'b0;
                if (inta_rise) state_d = WAIT2;
            end
            WAIT2: begin
                int_d = 1'b0;
                if (inta_fall) begin
                    state_d = ACK2;
                    data_d  = {icw2_vec, idx_q};
                    oe_d    = 1'b1;
                end
            end
            ACK2: begin
                int_d = 1'b0;
                if (inta_rise) begin
                    state_d = IDLE;
                    data_d  = 8'd0;
                    oe_d    = 1'b0;
                    if (aeoi && !spur_q) aeoi_clr = onehot(idx_q);
                end
            end
            default: state_d = IDLE;
        endcase
        // Clears are applied before the acknowledge set, so a set wins on a shared bit.
        isr_clr = aeoi_clr;
        if (eoi_ns && isr_q != 8'd0) isr_clr = isr_clr | onehot(top_isr[2:0]);
        if (eoi_sp)                  isr_clr = isr_clr | onehot(eoi_level);
        isr_d = (isr_q & ~isr_clr) | isr_set;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            sync_q    <= '1;
            edge_q    <= 1'b1;
            int_q     <= 1'b0;
            irr_clr_q <= 8'd0;
            isr_q     <= 8'd0;
            data_q    <= 8'd0;
            oe_q      <= 1'b0;
            idx_q     <= 3'd0;
            spur_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            sync_q    <= sync_d;
            edge_q    <= edge_d;
            int_q     <= int_d;
            irr_clr_q <= irr_clr_d;
            isr_q     <= isr_d;
            data_q    <= data_d;
            oe_q      <= oe_d;
            idx_q     <= idx_d;
            spur_q    <= spur_d;
        end
    end

    assign int_out  = int_q;
    assign irr_clr  = irr_clr_q;
    assign isr      = isr_q;
    assign data_out = data_q;
    assign data_oe  = oe_q;

endmodule

// File: tb/tb_pic_inta_sequencer.sv
// Directed bench for pic_inta_sequencer: acknowledge handshake, priority,
// nesting, AEOI, spurious acknowledge, EOI forms and reset mid-handshake.
module tb_pic_inta_sequencer;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] irr, imr;
    logic [4:0] icw2_vec;
    logic       aeoi, eoi_ns, eoi_sp;
    logic [2:0] eoi_level;
    logic       inta_n;
    logic       int_out, data_oe;
    logic [7:0] irr_clr, isr, data_out;

    int errors = 0;
    int checks = 0;
    int clr_cnt = 0;
    int c0;

    pic_inta_sequencer #(.SYNC_STAGES(2)) dut (
        .clk(clk), .rst_n(rst_n), .irr(irr), .imr(imr), .icw2_vec(icw2_vec),
        .aeoi(aeoi), .eoi_ns(eoi_ns), .eoi_sp(eoi_sp), .eoi_level(eoi_level),
        .inta_n(inta_n), .int_out(int_out), .irr_clr(irr_clr), .isr(isr),
        .data_out(data_out), .data_oe(data_oe)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (irr_clr != 8'd0) clr_cnt++;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Three edges: two synchroniser stages plus the edge-detect flop.
    task automatic inta_low();
        inta_n = 1'b0;
        repeat (3) tick();
    endtask

    task automatic inta_high();
        inta_n = 1'b1;
        repeat (3) tick();
    endtask

    task automatic handshake(input logic [7:0] req);
        irr = req;
        tick();
        inta_low();
        irr = 8'd0;
        inta_high();
        inta_low();
        inta_high();
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 1'b0; irr = 0; imr = 0; icw2_vec = 5'h11; aeoi = 0;
        eoi_ns = 0; eoi_sp = 0; eoi_level = 0; inta_n = 1'b1;
        repeat (2) tick();
        chk("rst_int", {7'd0, int_out}, 8'h00);
        chk("rst_clr", irr_clr, 8'h00);
        chk("rst_isr", isr, 8'h00);
        chk("rst_data", data_out, 8'h00);
        chk("rst_oe", {7'd0, data_oe}, 8'h00);
        rst_n = 1'b1;
        tick();

        // Basic vector
        irr = 8'h08;
        tick();
        chk("t1_int", {7'd0, int_out}, 8'h01);
        inta_low();
        chk("t1_clr", irr_clr, 8'h08);
        chk("t1_isr", isr, 8'h08);
        chk("t1_int_ack", {7'd0, int_out}, 8'h00);
        irr = 8'h00;
        inta_high();
        chk("t1_clr_once", irr_clr, 8'h00);
        inta_low();
        chk("t1_oe", {7'd0, data_oe}, 8'h01);
        chk("t1_vec", data_out, 8'h8B);
        inta_high();
        chk("t1_oe_off", {7'd0, data_oe}, 8'h00);
        chk("t1_data_off", data_out, 8'h00);
        chk("t1_isr_hold", isr, 8'h08);
        eoi_sp = 1'b1; eoi_level = 3'd3;
        tick();
        eoi_sp = 1'b0;
        chk("t1_eoi", isr, 8'h00);

        // Priority and masking
        irr = 8'h14; imr = 8'h04;
        tick();
        chk("t2_int", {7'd0, int_out}, 8'h01);
        inta_low();
        chk("t2_clr", irr_clr, 8'h10);
        irr = 8'h04;
        inta_high();
        inta_low();
        chk("t2_vec", data_out, 8'h8C);
        inta_high();
        chk("t2_isr", isr, 8'h10);
        irr = 8'h01;
        tick();
        chk("t2_preempt", {7'd0, int_out}, 8'h01);
        irr = 8'h00; imr = 8'h00; eoi_ns = 1'b1;
        tick();
        eoi_ns = 1'b0;
        chk("t2_eoi", isr, 8'h00);

        // Nesting block
        handshake(8'h04);
        chk("t3_isr", isr, 8'h04);
        irr = 8'h08;
        tick();
        chk("t3_blocked", {7'd0, int_out}, 8'h00);
        eoi_ns = 1'b1;
        tick();
        eoi_ns = 1'b0;
        chk("t3_eoi", isr, 8'h00);
        tick();
        chk("t3_int", {7'd0, int_out}, 8'h01);
        irr = 8'h00;
        tick();
        chk("t3_int_drop", {7'd0, int_out}, 8'h00);

        // AEOI
        aeoi = 1'b1; irr = 8'h40;
        c0 = clr_cnt;
        tick();
        chk("t4_int", {7'd0, int_out}, 8'h01);
        inta_low();
        chk("t4_clr", irr_clr, 8'h40);
        chk("t4_isr_set", isr, 8'h40);
        tick();
        chk("t4_clr_off", irr_clr, 8'h00);
        irr = 8'h00;
        inta_high();
        inta_low();
        chk("t4_vec", data_out, 8'h8E);
        inta_high();
        chk("t4_isr", isr, 8'h00);
        chk("t4_clr_count", 8'(clr_cnt - c0), 8'h01);
        aeoi = 1'b0;

        // Spurious acknowledge
        irr = 8'h02;
        tick();
        chk("t5_int", {7'd0, int_out}, 8'h01);
        irr = 8'h00;
        tick();
        chk("t5_int_drop", {7'd0, int_out}, 8'h00);
        c0 = clr_cnt;
        inta_low();
        chk("t5_isr", isr, 8'h00);
        inta_high();
        inta_low();
        chk("t5_vec", data_out, 8'h8F);
        inta_high();
        chk("t5_no_clr", 8'(clr_cnt - c0), 8'h00);

        // Specific and combined EOI
        handshake(8'h20);
        handshake(8'h01);
        chk("t6_isr", isr, 8'h21);
        eoi_sp = 1'b1; eoi_level = 3'd5;
        tick();
        eoi_sp = 1'b0;
        chk("t6_eoi_sp", isr, 8'h01);
        eoi_ns = 1'b1; eoi_sp = 1'b1; eoi_level = 3'd3;
        tick();
        eoi_ns = 1'b0; eoi_sp = 1'b0;
        chk("t6_eoi_both", isr, 8'h00);

        // Reset mid-handshake
        irr = 8'h08;
        tick();
        inta_low();
        chk("t7_isr", isr, 8'h08);
        irr = 8'h00;
        inta_high();
        chk("t7_wait_int", {7'd0, int_out}, 8'h00);
        inta_n = 1'b0;
        tick();
        rst_n = 1'b0;
        #1;
        chk("t7_rst_int", {7'd0, int_out}, 8'h00);
        chk("t7_rst_clr", irr_clr, 8'h00);
        chk("t7_rst_isr", isr, 8'h00);
        chk("t7_rst_data", data_out, 8'h00);
        chk("t7_rst_oe", {7'd0, data_oe}, 8'h00);
        inta_n = 1'b1;
        tick();
        rst_n = 1'b1;
        repeat (4) tick();
        chk("t7_no_oe", {7'd0, data_oe}, 8'h00);
        chk("t7_no_data", data_out, 8'h00);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
